// File: rtl/drowsiness_detector.sv
// Single-neuron core: builds a signed weight table on Start, then produces
// ReLU(sum(in[i]*w[i]) >>> FRAC) saturated to an unsigned W-bit result.
module drowsiness_detector #(
  parameter int           N      = 10,
  parameter int           W      = 10,
  parameter logic [W-1:0] W_SEED = W'(1),
  parameter logic [W-1:0] W_STEP = W'(1),
  parameter int           FRAC   = 4
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                Start,
  input  logic [W-1:0]        in [N],
  output logic signed [W-1:0] dataRead,
  output logic signed [W-1:0] data,
  output logic [W-1:0]        outVal,
  output logic [1:0]          state_o
);

  localparam int IDX_W = $clog2(N + 1);
  localparam int PRD_W = 2 * W + 1;
  localparam int ACC_W = 2 * W + $clog2(N) + 2;

  localparam logic signed [PRD_W-1:0] P_MAX = PRD_W'((1 << (W - 1)) - 1);
  localparam logic signed [PRD_W-1:0] P_MIN = -P_MAX - PRD_W'(1);
  localparam logic signed [ACC_W-1:0] O_MAX = ACC_W'((1 << W) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W-1:0]     mem_q [N];

  logic [31:0]             gen_full;
  logic signed [W-1:0]     gen_w;
  logic signed [W-1:0]     rd_w;
  logic [W-1:0]            rd_in;
  logic signed [PRD_W-1:0] prod;
  logic signed [PRD_W-1:0] prod_sh;
  logic signed [W-1:0]     prod_sat;
  logic signed [ACC_W-1:0] acc_sh;
  logic [W-1:0]            relu_out;
  logic                    last_idx;

  assign state_o = state_q;

  always_comb begin
    // Weight generator wraps modulo 2^W; the low W bits are reinterpreted as signed.
    gen_full = 32'(W_SEED) + 32'(idx_q) * 32'(W_STEP);
    gen_w    = $signed(gen_full[W-1:0]);
    rd_w     = mem_q[idx_q];
    rd_in    = in[idx_q];
    last_idx = (idx_q == IDX_W'(N - 1));

    prod    = PRD_W'($signed({1'b0, rd_in})) * PRD_W'(rd_w);
    prod_sh = prod >>> FRAC;
    if (prod_sh > P_MAX) begin
      prod_sat = P_MAX[W-1:0];
    end else if (prod_sh < P_MIN) begin
      prod_sat = P_MIN[W-1:0];
    end else begin
      prod_sat = prod_sh[W-1:0];
    end

    acc_sh = acc_q >>> FRAC;
    if (acc_q[ACC_W-1] || (acc_q == '0)) begin
      relu_out = '0;
    end else if (acc_sh > O_MAX) begin
      relu_out = '1;
    end else begin
      relu_out = acc_sh[W-1:0];
    end
  end

  // Start is a level request sampled only in IDLE; once a run begins it always
  // completes, and DONE re-arms only after Start has been seen low.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      dataRead <= '0;
      data     <= '0;
      outVal   <= '0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_INIT;
            idx_q   <= '0;
          end
        end
        S_INIT: begin
          mem_q[idx_q] <= gen_w;
          data         <= gen_w;
          if (last_idx) begin
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= S_ACC;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_ACC: begin
          dataRead <= rd_w;
          data     <= prod_sat;
          acc_q    <= acc_q + ACC_W'(prod);
          if (last_idx) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          outVal <= relu_out;
          if (!Start) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drowsiness_detector.sv
// Bench for drowsiness_detector: two instances (positive and wrapped-negative weight
// seeds) run in lockstep against a plain-arithmetic neuron model.
module tb_drowsiness_detector;

  localparam int N       = 10;
  localparam int W       = 10;
  localparam int FRAC    = 4;
  localparam int SEED0   = 1;
  localparam int SEED1   = 'h3FB;
  localparam int STEP    = 1;
  localparam int ST_INIT = 1;
  localparam int ST_ACC  = 2;
  localparam int ST_DONE = 3;

  typedef struct {
    int d0;
    int d1;
    int r0;
    int r1;
    bit is_acc;
  } seq_t;

  typedef struct {
    int o0;
    int o1;
    int cyc;
  } out_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [W-1:0]        in_v [N];
  logic signed [W-1:0] r0, r1, d0, d1;
  logic [W-1:0]        o0, o1;
  logic [1:0]          st0, st1;

  seq_t exp_seq_q[$];
  out_t exp_out_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   prev_st, prev2;
  int   last_d0, last_d1, last_r0, last_r1, last_o0, last_o1;
  seq_t mon_e;
  out_t mon_o;

  drowsiness_detector #(.N(N), .W(W), .W_SEED(10'd1), .W_STEP(10'd1), .FRAC(FRAC)) dut0 (
    .Clock(clk), .Rst(rst_n), .Start(start), .in(in_v),
    .dataRead(r0), .data(d0), .outVal(o0), .state_o(st0)
  );

  drowsiness_detector #(.N(N), .W(W), .W_SEED(10'h3FB), .W_STEP(10'd1), .FRAC(FRAC)) dut1 (
    .Clock(clk), .Rst(rst_n), .Start(start), .in(in_v),
    .dataRead(r1), .data(d1), .outVal(o1), .state_o(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference model
  function automatic int wgen(input int seed, input int i);
    int v;
    v = (seed + i * STEP) % (1 << W);
    if (v >= (1 << (W - 1))) v -= (1 << W);
    return v;
  endfunction

  function automatic int floor_div(input int x, input int d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int sat_s(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic int relu_out(input int s);
    int q;
    if (s <= 0) return 0;
    q = s / (1 << FRAC);
    return (q > 1023) ? 1023 : q;
  endfunction

  task automatic push_expected();
    seq_t e;
    out_t o;
    int   p0, p1, s0, s1;
    for (int i = 0; i < N; i++) begin
      e.d0 = wgen(SEED0, i);
      e.d1 = wgen(SEED1, i);
      e.r0 = 0;
      e.r1 = 0;
      e.is_acc = 1'b0;
      exp_seq_q.push_back(e);
    end
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < N; i++) begin
      p0 = int'(in_v[i]) * wgen(SEED0, i);
      p1 = int'(in_v[i]) * wgen(SEED1, i);
      s0 += p0;
      s1 += p1;
      e.d0 = sat_s(floor_div(p0, 1 << FRAC));
      e.d1 = sat_s(floor_div(p1, 1 << FRAC));
      e.r0 = wgen(SEED0, i);
      e.r1 = wgen(SEED1, i);
      e.is_acc = 1'b1;
      exp_seq_q.push_back(e);
    end
    o.o0  = relu_out(s0);
    o.o1  = relu_out(s1);
    o.cyc = cyc + 1 + 2 * N + 1;
    exp_out_q.push_back(o);
  endtask

  // driver tasks (called at posedge + 2)
  task automatic fill(input int v);
    for (int i = 0; i < N; i++) in_v[i] = W'(v);
  endtask

  task automatic do_run(input bit drop_early, input int hold_extra, input int abort_at);
    int k;
    push_expected();
    start = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at + 1) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_seq_q.delete();
      exp_out_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      push_expected();
    end
    k = 0;
    while (exp_out_q.size() != 0 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
      if (drop_early && k == 3) start = 1'b0;
    end
    if (exp_out_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: result still pending after %0d cycles, need 0 pending", k);
      exp_out_q.delete();
      exp_seq_q.delete();
    end
    repeat (hold_extra) begin
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_state", int'(st0), 0);
      chk("rst_data0", int'(d0), 0);
      chk("rst_data1", int'(d1), 0);
      chk("rst_rd0", int'(r0), 0);
      chk("rst_rd1", int'(r1), 0);
      chk("rst_out0", int'(o0), 0);
      chk("rst_out1", int'(o1), 0);
      prev_st = 0;
      prev2   = 0;
      last_d0 = 0; last_d1 = 0; last_r0 = 0;
      last_r1 = 0; last_o0 = 0; last_o1 = 0;
    end else begin
      if (prev_st == ST_INIT || prev_st == ST_ACC) begin
        if (exp_seq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL seq_extra: DUT in phase %0d with no expected step pending", prev_st);
        end else begin
          mon_e = exp_seq_q.pop_front();
          chk("phase_is_acc", int'(prev_st == ST_ACC), int'(mon_e.is_acc));
          last_d0 = mon_e.d0;
          last_d1 = mon_e.d1;
          if (mon_e.is_acc) begin
            last_r0 = mon_e.r0;
            last_r1 = mon_e.r1;
          end
        end
      end
      if (prev_st == ST_DONE && prev2 != ST_DONE) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra: DONE reached with no expected result pending");
        end else begin
          mon_o = exp_out_q.pop_front();
          chk("out_cycle", cyc, mon_o.cyc);
          last_o0 = mon_o.o0;
          last_o1 = mon_o.o1;
        end
      end
      chk("data0", int'(d0), last_d0);
      chk("data1", int'(d1), last_d1);
      chk("dataRead0", int'(r0), last_r0);
      chk("dataRead1", int'(r1), last_r1);
      chk("outVal0", int'(o0), last_o0);
      chk("outVal1", int'(o1), last_o1);
      prev2   = prev_st;
      prev_st = int'(st0);
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    fill(200);  do_run(1'b0, 0, 0);
    fill(0);    do_run(1'b0, 0, 0);
    fill(1023); do_run(1'b0, 0, 0);
    fill(200);  do_run(1'b0, 0, 12);
    fill(200);  do_run(1'b0, 6, 0);
    do_run(1'b1, 0, 0);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++) begin
        case (r % 3)
          0: in_v[i] = W'($urandom_range(0, 1023));
          1: in_v[i] = W'($urandom_range(900, 1023));
          default: in_v[i] = W'($urandom_range(0, 60));
        endcase
      end
      do_run(1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
    end

    chk("seq_q_drained", exp_seq_q.size(), 0);
    chk("out_q_drained", exp_out_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
